// File: rtl/ssd_scan_mux_if.sv
// Bundle of display-side signals for the seven-segment scan multiplexer.
// The master drives the value to show and the enable; the slave returns the scan outputs.
interface ssd_scan_mux_if #(
   parameter int DIGITS = 4
);
   logic                  en;
   logic [4*DIGITS-1:0]   value;
   logic [3:0]            nibble;
   logic [DIGITS-1:0]     digit_en;
   logic                  frame_start;

   modport master (
      output en,
      output value,
      input  nibble,
      input  digit_en,
      input  frame_start
   );

   modport slave (
      input  en,
      input  value,
      output nibble,
      output digit_en,
      output frame_start
   );
endinterface

// File: rtl/ssd_scan_mux.sv
// Time-multiplexed hex display scanner: one digit per CLK_DIV-cycle slot, blanked for BLANK_CYCLES at slot start.
// Optional macro SSD_LEADING_ZERO_BLANK_EN darkens slots whose digit and all higher digits are zero.
module ssd_scan_mux #(
   parameter int DIGITS       = 4,
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic           i_clk,
   input  logic           i_rst,
   ssd_scan_mux_if.slave  bus
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] BLANK_TH = CW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

   logic [CW-1:0]         r_cnt;
   logic [IW-1:0]         r_idx;
   logic [4*DIGITS-1:0]   r_shadow;
   logic [3:0]            r_nibble;
   logic [DIGITS-1:0]     r_digit_en;
   logic                  r_frame_start;

   logic                  w_slot0;
   logic                  w_capture;
   logic [4*DIGITS-1:0]   w_shadow_nxt;
   logic [3:0]            w_nib;
   logic [DIGITS-1:0]     w_onehot;
   logic                  w_lit;
   logic                  w_cnt_wrap;
   logic                  w_idx_wrap;

   assign w_slot0      = (r_cnt == '0) && (r_idx == '0);
   assign w_capture    = bus.en && w_slot0;
   assign w_shadow_nxt = w_capture ? bus.value : r_shadow;
   assign w_onehot     = DIGITS'(1) << r_idx;
   assign w_cnt_wrap   = (r_cnt == CNT_MAX);
   assign w_idx_wrap   = (r_idx == IDX_MAX);

   // Uses the next shadow so slot 0 shows the freshly captured digit immediately.
   always_comb begin
      w_nib = 4'h0;
      for (int k = 0; k < DIGITS; k++) begin
         if (r_idx == IW'(k)) w_nib = w_shadow_nxt[4*k +: 4];
      end
   end

`ifdef SSD_LEADING_ZERO_BLANK_EN
   logic w_upper_zero;

   // Walk from the top digit down; a slot is dark if it and everything above it is zero.
   always_comb begin
      w_upper_zero = 1'b1;
      w_lit        = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         w_upper_zero = w_upper_zero & (w_shadow_nxt[4*k +: 4] == 4'h0);
         if (r_idx == IW'(k)) w_lit = ~w_upper_zero;
      end
   end
`else
   assign w_lit = 1'b1;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt         <= '0;
         r_idx         <= '0;
         r_shadow      <= '0;
         r_nibble      <= 4'h0;
         r_digit_en    <= '0;
         r_frame_start <= 1'b0;
      end else if (!bus.en) begin
         // Freeze position, shadow and nibble; only the visible outputs go dark.
         r_digit_en    <= '0;
         r_frame_start <= 1'b0;
      end else begin
         r_shadow      <= w_shadow_nxt;
         r_nibble      <= w_nib;
         r_frame_start <= w_slot0;
         r_digit_en    <= ((r_cnt >= BLANK_TH) && w_lit) ? w_onehot : '0;
         if (w_cnt_wrap) begin
            r_cnt <= '0;
            r_idx <= w_idx_wrap ? '0 : r_idx + IW'(1);
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign bus.nibble      = r_nibble;
   assign bus.digit_en    = r_digit_en;
   assign bus.frame_start = r_frame_start;
endmodule

// File: tb/tb_ssd_scan_mux.sv
// Self-checking bench for ssd_scan_mux with DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2.
// Expected outputs come from a frame-position model pushed into a queue each cycle.
module tb_ssd_scan_mux;
   localparam int DIGITS  = 4;
   localparam int CLK_DIV = 8;
   localparam int BLANK   = 2;
   localparam int FRAME   = DIGITS * CLK_DIV;
   localparam int W       = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ssd_scan_mux_if #(.DIGITS(DIGITS)) bus ();

   ssd_scan_mux #(
      .DIGITS       (DIGITS),
      .CLK_DIV      (CLK_DIV),
      .BLANK_CYCLES (BLANK)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // {frame_start, digit_en[3:0], nibble[3:0], nibble_check}
   logic [W-1:0] exp_q[$];

   int          m_pos;
   logic [15:0] m_shadow;
   logic [3:0]  m_nib;
   logic        use_tbl;
   logic [3:0]  tbl_lit;

   typedef struct {
      logic [15:0] value;
      logic [3:0]  lit_lz;
   } vec_t;

   vec_t vecs[8];

   function automatic logic [3:0] lz_mask(input logic [15:0] v);
      logic [3:0] m;
`ifdef SSD_LEADING_ZERO_BLANK_EN
      m[0] = 1'b1;
      for (int s = 1; s < DIGITS; s++) m[s] = ((v >> (4*s)) != 16'h0);
`else
      m = 4'hF;
`endif
      return m;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input string tag);
      logic [W-1:0] e;
      logic [3:0]   lit;
      logic [3:0]   de;
      int           c;
      int           s;
      if (rst) begin
         m_pos    = 0;
         m_shadow = 16'h0;
         m_nib    = 4'h0;
         e = {1'b0, 4'h0, 4'h0, 1'b1};
      end else if (!bus.en) begin
         e = {1'b0, 4'h0, m_nib, 1'b1};
      end else begin
         c = m_pos % CLK_DIV;
         s = m_pos / CLK_DIV;
         if (m_pos == 0) m_shadow = bus.value;
         lit   = use_tbl ? tbl_lit : lz_mask(m_shadow);
         m_nib = m_shadow[4*s +: 4];
         de    = (c >= BLANK && lit[s]) ? 4'(1 << s) : 4'h0;
         e = {(m_pos == 0), de, m_nib, (c >= 1)};
         m_pos = (m_pos + 1) % FRAME;
      end
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      check({tag, ".frame_start"}, 8'(bus.frame_start), 8'(e[9]));
      check({tag, ".digit_en"}, 8'(bus.digit_en), 8'(e[8:5]));
      if (e[0]) check({tag, ".nibble"}, 8'(bus.nibble), 8'(e[4:1]));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step("reset");
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      bus.en    = 1'b0;
      bus.value = 16'h0;
      use_tbl   = 1'b0;
      tbl_lit   = 4'hF;
      m_pos     = 0;
      m_shadow  = 16'h0;
      m_nib     = 4'h0;

      vecs[0] = '{16'h1234, 4'b1111};
      vecs[1] = '{16'h0040, 4'b0011};
      vecs[2] = '{16'h0000, 4'b0001};
      vecs[3] = '{16'hABCD, 4'b1111};
      vecs[4] = '{16'h0100, 4'b0111};
      vecs[5] = '{16'h000F, 4'b0001};
      vecs[6] = '{16'h1000, 4'b1111};
      vecs[7] = '{16'h0A0B, 4'b0111};

      @(negedge clk);
      step("reset");
      bus.en    = 1'b1;
      bus.value = 16'hFFFF;
      step("rst_over_en");

      foreach (vecs[i]) begin
         do_reset();
         bus.en    = 1'b1;
         bus.value = vecs[i].value;
         use_tbl   = 1'b1;
`ifdef SSD_LEADING_ZERO_BLANK_EN
         tbl_lit   = vecs[i].lit_lz;
`else
         tbl_lit   = 4'hF;
`endif
         repeat (FRAME + 1) step($sformatf("vec%0d", i));
         use_tbl = 1'b0;
      end

      // Value change mid-frame must not disturb the current frame.
      do_reset();
      bus.value = 16'h1234;
      repeat (2*CLK_DIV) step("midframe");
      bus.value = 16'hABCD;
      repeat (2*CLK_DIV) step("midframe");
      repeat (FRAME + 1) step("midframe_next");

      // Reset at slot 2 cycle 5 restarts the scan with a fresh capture.
      do_reset();
      bus.value = 16'h1234;
      repeat (2*CLK_DIV + 5) step("pre_rst");
      rst = 1'b1;
      step("mid_rst");
      rst = 1'b0;
      bus.value = 16'h5A0F;
      repeat (FRAME + 1) step("post_rst");

      // Enable low for 10 cycles at slot 1 cycle 4, then resume.
      do_reset();
      bus.value = 16'h1234;
      repeat (CLK_DIV + 4) step("pre_hold");
      bus.en = 1'b0;
      repeat (10) step("hold");
      bus.en = 1'b1;
      repeat (FRAME) step("resume");

      // Random values with random enable gaps.
      repeat (4) begin
         do_reset();
         bus.value = 16'($urandom_range(0, 16'hFFFF));
         repeat (FRAME + 8) begin
            bus.en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) bus.value = 16'($urandom_range(0, 16'hFFFF));
            step("random");
         end
         bus.en = 1'b1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ssd_scan_mux.md
SSD_SCAN_MUX -- requirements
Module: ssd_scan_mux

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter CLK_DIV, default 50000, clock cycles per digit slot; legal range 2..2^20.
REQ-003 Parameter BLANK_CYCLES, default 2, anti-ghosting dead time at slot start; legal range 1..CLK_DIV-1.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  scan enable; low freezes the scan and darkens the display.
REQ-007 value  input  4*DIGITS  hex value to display; nibble k drives digit k (digit 0 = least significant).
REQ-008 nibble  output  4  current digit code, fed directly to the downstream hex-to-segment decoder.
REQ-009 digit_en  output  DIGITS  one-hot active-high digit enable; all-zero means dark.
REQ-010 frame_start  output  1  one-cycle pulse marking cycle 0 of slot 0.

Function
REQ-011 The block SHALL hold a slot counter cnt (0..CLK_DIV-1) and a digit index idx (0..DIGITS-1); cnt increments each enabled cycle; at CLK_DIV-1 it wraps to 0 and idx advances, wrapping DIGITS-1 -> 0.
REQ-012 The block SHALL capture value into a shadow register in every enabled cycle with cnt==0 and idx==0; value changes at any other time SHALL NOT affect the current frame.
REQ-013 All outputs SHALL be registered; nibble SHALL equal shadow digit idx from slot cycle 1 through CLK_DIV-1 and SHALL be stable for that whole span.
REQ-014 digit_en SHALL be all-zero for slot cycles 0..BLANK_CYCLES-1 and one-hot bit idx for cycles BLANK_CYCLES..CLK_DIV-1.
REQ-015 frame_start SHALL be high in exactly the cycle following an enabled cycle with cnt==0 and idx==0, i.e. once per DIGITS*CLK_DIV enabled cycles.
REQ-016 While en is low, cnt, idx and shadow SHALL hold, digit_en SHALL be all-zero, frame_start SHALL be low and nibble SHALL hold; on en rising the scan SHALL resume from the held cnt/idx.
REQ-017 cnt width SHALL be $clog2(CLK_DIV) and idx width $clog2(DIGITS) (minimum 1); no arithmetic SHALL overflow for any legal parameter set.
REQ-018 Simultaneous en low and slot wrap: hold takes priority; no advance occurs.

Reset
REQ-019 With rst high on a clock edge: cnt=0, idx=0, shadow=0, nibble=0, digit_en=0, frame_start=0; rst overrides en.
REQ-020 The first enabled cycle after rst deassertion SHALL be slot-0 cycle 0 and SHALL capture value; reset asserted mid-slot SHALL take effect on the next edge with no partial slot completed.

Configuration
REQ-021 Macro SSD_LEADING_ZERO_BLANK_EN defined: in slot k>0, digit_en SHALL stay all-zero for the whole slot if shadow digits k..DIGITS-1 are all zero; digit 0 is always lit, so shadow 0 shows a single "0".
REQ-022 Macro undefined: every digit SHALL be lit per REQ-014 regardless of value; no leading-zero logic synthesized.

Verification (DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2)
REQ-023 rst, then value=0x1234, en=1 -> frame_start pulse; slot 0: digit_en=0000 cycles 0-1, 0001 cycles 2-7, nibble=4; slots 1-3 nibble=3,2,1 with digit_en 0010,0100,1000; frame_start repeats every 32 cycles.
REQ-024 value 0x1234 -> 0xABCD during slot 2 -> slots 2,3 still show 2,1; next frame shows D,C,B,A.
REQ-025 rst pulsed at slot 2 cycle 5 -> next edge all outputs zero; scan restarts at slot 0 cycle 0 with fresh capture.
REQ-026 en low for 10 cycles at slot 1 cycle 4 -> digit_en=0000, frame_start=0, nibble held; after en high, slot 1 completes remaining cycles 4-7 then slot 2 starts.
REQ-027 Macro defined, value=0x0040 -> slots 0,1 lit (nibbles 0,4), slots 2,3 dark; value=0x0000 -> only digit 0 lit, nibble 0; macro undefined, same values -> all four digits lit.
